p2s_lane_tx: RTL and testbench
==============================

Name: p2s_lane_tx

Overview:
Upstream transmit stage for the 4-lane serial-to-parallel receiver. It accepts 32-bit words over a valid/ready handshake and stripes them one byte per lane. Each byte is serialised over WIDTH clock cycles onto a 1-bit lane. When no word is available, the block sends an idle symbol so the receiver always sees continuous symbol framing. It has a 1-entry holding buffer and a shared bit counter that frames all lanes together.

Parameters:
WIDTH, 8, bits per lane symbol (shift-register length)
LANES, 4, number of serial lanes
IDLE_SYM, 8'hBC, symbol loaded on every lane when no data word is available

Ports:
CLK  input  1  single clock, rising edge
RESET  input  1  synchronous, active-high reset
ENB  input  1  global enable; when low, all state freezes
DIR  input  1  bit order: 0 = MSB first, 1 = LSB first; sampled only at symbol load
IN_DATA  input  LANES*WIDTH  word; lane k takes IN_DATA[WIDTH*k+WIDTH-1 : WIDTH*k]
IN_VALID  input  1  IN_DATA is valid
IN_READY  output  1  block accepts IN_DATA on this edge
OUT_LANE  output  LANES  serial bit per lane; bit k = lane k
OUT_FRAME  output  1  high during the first bit of each symbol (cnt==0)
OUT_IDLE  output  1  high for the whole symbol when the current symbol is IDLE_SYM fill

Behaviour:
- Clock and reset: one clock (CLK); reset is synchronous and active-high (RESET). All state updates only on CLK rising edges with ENB=1, except reset.
- Reset values: cnt=WIDTH-1, all shift registers=0, OUT_LANE=0, buffer empty, OUT_IDLE=1, OUT_FRAME=0.
- IN_READY = ENB & ~RESET & (~buf_full | load). This is combinational from state. There is no path from IN_VALID to IN_READY.
- Bit counter cnt (width clog2(WIDTH)):
  - Increments each enabled cycle.
  - Wraps from WIDTH-1 to 0.
  - The load edge is the enabled edge where cnt==WIDTH-1.
- At the load edge:
  - If buffer is full, each lane's shift register gets its byte from the buffer, buffer is emptied, and OUT_IDLE_next=0.
  - Otherwise each lane's shift register gets IDLE_SYM, and OUT_IDLE_next=1.
  - The loaded byte is bit-reversed when DIR=1.
  - Handshake at the load edge: if IN_VALID&IN_READY on the same edge, the buffer refills with the new word, so it remains full.
  - There is no bypass: a word accepted on the load edge while the buffer was empty is held and sent in the next symbol.
- On non-load enabled edges, every shift register shifts left by 1 with zero fill.
- OUT_LANE[k] is the shift register's MSB (bit WIDTH-1), driven directly from the flop.
- Handshake on non-load edges: IN_VALID&IN_READY with buffer empty writes the buffer. IN_DATA is ignored when IN_READY=0.
- Latency: a word accepted at edge N appears with its first bit on OUT_LANE after load edge L, the first load edge after N. L - N ranges 1..WIDTH cycles.
- ENB=0: cnt, shift registers, buffer, OUT_* hold; IN_READY=0; no transfer.
- Reset mid-symbol: the partial symbol is discarded and a buffered word is dropped. The first enabled edge after reset is a load edge.
- Simultaneous RESET and IN_VALID: reset wins; no transfer.
- DIR change mid-symbol: no effect until the next load edge.

Decomposition:
- Shared package/header holds:
  - default IDLE_SYM (8'hBC)
  - DIR encodings (DIR_MSB_FIRST=0, DIR_LSB_FIRST=1)
  - LANES/WIDTH defaults, shared with s2p_cond
- One sub-module is natural: p2s_shift_reg (a WIDTH-bit load/shift-left register with enable and optional reverse on load), instantiated LANES times.
- Counter, buffer and handshake logic stay in the top module.

Test Plan:
- Reset, then ENB=1, IN_VALID=0 for 16 cycles -> every lane emits 1,0,1,1,1,1,0,0 twice; OUT_FRAME pulses on cycles 1 and 9 after reset release; OUT_IDLE=1 throughout.
- DIR=0, one word 32'hA53C0F81 accepted during an idle symbol -> next symbol: lane3 = 10100101, lane2 = 00111100, lane1 = 00001111, lane0 = 10000001, with OUT_IDLE=0. The following symbol returns to 0xBC.
- DIR=1, word 32'h0000_00BC -> lane0 emits 0,0,1,1,1,1,0,1; lanes 3..1 emit 8 zeros.
- IN_VALID held high with 3 words -> IN_READY=1 on the first accept, then 0 until each load edge. The symbols are sent back-to-back with no idle gap, in order, and OUT_IDLE=0 for all three.
- ENB dropped for 5 cycles at bit 3 of a symbol -> OUT_LANE and OUT_FRAME frozen and IN_READY=0. Resumes at bit 4 with the total symbol still 8 enabled cycles.
- RESET pulsed at bit 5 with a word buffered -> OUT_LANE=0 the cycle after reset, and the buffered word never appears. The first symbol after reset is 0xBC.

Source files
------------

// File: rtl/p2s_lane_tx_pkg.sv
// Shared definitions for the parallel-to-serial lane transmitter.
// Holds the default lane geometry (shared with s2p_cond), the default idle
// fill symbol and the bit-order encoding used by DIR.
package p2s_lane_tx_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_LANES = 4;
    localparam logic [7:0]  DEF_IDLE_SYM = 8'hBC;

    typedef enum logic {
        DIR_MSB_FIRST = 1'b0,
        DIR_LSB_FIRST = 1'b1
    } dir_e;

endpackage

// File: rtl/p2s_shift_reg.sv
// One lane's WIDTH-bit serialiser: parallel load (optionally bit-reversed)
// or shift left with zero fill, gated by a clock enable.
// Ports: clk, rst (sync, active-high), en, load, rev, load_data, msb (lane bit).
module p2s_shift_reg
    import p2s_lane_tx_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic             rev,
    input  logic [WIDTH-1:0] load_data,
    output logic             msb
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] load_val_c;

    // Reversing on load lets LSB-first lanes share the MSB-out shifter.
    always_comb begin
        load_val_c = load_data;
        if (rev) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                load_val_c[i] = load_data[WIDTH-1-i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else if (en) begin
            if (load) begin
                sr_q <= load_val_c;
            end else begin
                sr_q <= {sr_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign msb = sr_q[WIDTH-1];

endmodule

// File: rtl/p2s_lane_tx.sv
// Parallel-to-serial lane transmitter. Accepts LANES*WIDTH-bit words over
// valid/ready into a 1-entry buffer and stripes them one symbol per lane,
// all lanes framed by one shared bit counter. Idle symbols fill empty slots.
// Ports: CLK, RESET (sync, active-high), ENB (global enable), DIR (bit order,
// sampled at symbol load), IN_DATA/IN_VALID/IN_READY (input handshake,
// IN_READY combinational), OUT_LANE (one bit per lane), OUT_FRAME (first bit
// of symbol), OUT_IDLE (current symbol is idle fill).
module p2s_lane_tx
    import p2s_lane_tx_pkg::*;
#(
    parameter int unsigned     WIDTH    = DEF_WIDTH,
    parameter int unsigned     LANES    = DEF_LANES,
    parameter logic [WIDTH-1:0] IDLE_SYM = WIDTH'(DEF_IDLE_SYM)
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   ENB,
    input  logic                   DIR,
    input  logic [LANES*WIDTH-1:0] IN_DATA,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    output logic [LANES-1:0]       OUT_LANE,
    output logic                   OUT_FRAME,
    output logic                   OUT_IDLE
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [CW-1:0]          cnt_q;
    logic [LANES*WIDTH-1:0] buf_q;
    logic                   buf_full_q;
    logic                   load_c;
    logic                   fire_c;
    logic                   rev_c;

    assign load_c   = (cnt_q == CW'(WIDTH - 1));
    // A load edge drains the buffer, so it may refill on that same edge.
    assign IN_READY = ENB & ~RESET & (~buf_full_q | load_c);
    assign fire_c   = IN_VALID & IN_READY;
    assign rev_c    = (dir_e'(DIR) == DIR_LSB_FIRST);

    // Shared bit counter, holding buffer and output framing flags.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q      <= CW'(WIDTH - 1);
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            OUT_IDLE   <= 1'b1;
            OUT_FRAME  <= 1'b0;
        end else if (ENB) begin
            cnt_q      <= load_c ? '0 : cnt_q + CW'(1);
            OUT_FRAME  <= load_c;
            buf_full_q <= (buf_full_q & ~load_c) | fire_c;
            if (load_c) begin
                OUT_IDLE <= ~buf_full_q;
            end
            if (fire_c) begin
                buf_q <= IN_DATA;
            end
        end
    end

    // One serialiser per lane; lane k carries slice k of the buffered word.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [WIDTH-1:0] lane_data_c;

        assign lane_data_c = buf_full_q ? buf_q[WIDTH*k +: WIDTH] : IDLE_SYM;

        p2s_shift_reg #(
            .WIDTH(WIDTH)
        ) u_sr (
            .clk      (CLK),
            .rst      (RESET),
            .en       (ENB),
            .load     (load_c),
            .rev      (rev_c),
            .load_data(lane_data_c),
            .msb      (OUT_LANE[k])
        );
    end

endmodule

// File: tb/tb_p2s_lane_tx.sv
// Directed testbench for p2s_lane_tx (WIDTH=8, LANES=4, IDLE_SYM=8'hBC).
module tb_p2s_lane_tx;

    logic        clk;
    logic        reset;
    logic        enb;
    logic        dir;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  out_lane;
    logic        out_frame;
    logic        out_idle;

    int total;
    int bad;

    logic [7:0] idle_v;

    p2s_lane_tx #(
        .WIDTH   (8),
        .LANES   (4),
        .IDLE_SYM(8'hBC)
    ) dut (
        .CLK      (clk),
        .RESET    (reset),
        .ENB      (enb),
        .DIR      (dir),
        .IN_DATA  (in_data),
        .IN_VALID (in_valid),
        .IN_READY (in_ready),
        .OUT_LANE (out_lane),
        .OUT_FRAME(out_frame),
        .OUT_IDLE (out_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // MSB-first bit i of every lane of word w: {lane3, lane2, lane1, lane0}.
    function automatic logic [3:0] lanes_bit(input logic [31:0] w, input int i);
        return {w[31-i], w[23-i], w[15-i], w[7-i]};
    endfunction

    task automatic test_reset();
        reset    = 1'b1;
        enb      = 1'b1;
        dir      = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'hFFFF_FFFF;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL reset_ready got=%b exp=0", in_ready);
        end
        tick();
        tick();
        total++;
        if (out_lane !== 4'b0000) begin
            bad++; $display("FAIL reset_lane got=%b exp=0000", out_lane);
        end
        total++;
        if (out_idle !== 1'b1) begin
            bad++; $display("FAIL reset_idle got=%b exp=1", out_idle);
        end
        total++;
        if (out_frame !== 1'b0) begin
            bad++; $display("FAIL reset_frame got=%b exp=0", out_frame);
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_release_ready got=%b exp=1", in_ready);
        end
    endtask

    // Two idle symbols; also shows the word offered during reset was dropped.
    task automatic test_idle();
        for (int i = 0; i < 16; i++) begin
            tick();
            total++;
            if (out_lane !== {4{idle_v[7-(i%8)]}}) begin
                bad++; $display("FAIL idle_lane cyc=%0d got=%b exp=%b", i, out_lane, {4{idle_v[7-(i%8)]}});
            end
            total++;
            if (out_frame !== (i % 8 == 0)) begin
                bad++; $display("FAIL idle_frame cyc=%0d got=%b", i, out_frame);
            end
            total++;
            if (out_idle !== 1'b1) begin
                bad++; $display("FAIL idle_flag cyc=%0d got=%b exp=1", i, out_idle);
            end
        end
    endtask

    // MSB-first word accepted mid idle symbol; DIR toggled mid data symbol.
    task automatic test_word_msb();
        logic [31:0] w;
        w = 32'hA53C_0F81;
        tick();
        in_valid = 1'b1;
        in_data  = w;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL msb_ready got=%b exp=1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        repeat (6) tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if (out_lane !== lanes_bit(w, i)) begin
                bad++; $display("FAIL msb_lane bit=%0d got=%b exp=%b", i, out_lane, lanes_bit(w, i));
            end
            total++;
            if (out_idle !== 1'b0) begin
                bad++; $display("FAIL msb_idle bit=%0d got=%b exp=0", i, out_idle);
            end
            total++;
            if (out_frame !== (i == 0)) begin
                bad++; $display("FAIL msb_frame bit=%0d got=%b", i, out_frame);
            end
            if (i == 0) dir = 1'b1;
            if (i == 7) dir = 1'b0;
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if (out_lane !== {4{idle_v[7-i]}} || out_idle !== 1'b1) begin
                bad++; $display("FAIL msb_after_idle bit=%0d got=%b/%b exp=%b/1", i, out_lane, out_idle, {4{idle_v[7-i]}});
            end
        end
    endtask

    // LSB-first; word accepted on a load edge with empty buffer (no bypass).
    task automatic test_word_lsb();
        logic [7:0] lane0_exp;
        lane0_exp = 8'b0011_1101;
        dir      = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h0000_00BC;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL lsb_ready got=%b exp=1", in_ready);
        end
        tick();
        total++;
        if (out_idle !== 1'b1 || out_lane !== 4'b0000) begin
            bad++; $display("FAIL lsb_nobypass got=%b/%b exp=1/0000", out_idle, out_lane);
        end
        in_valid = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL lsb_full_ready got=%b exp=0", in_ready);
        end
        repeat (7) tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if (out_lane !== {3'b000, lane0_exp[7-i]}) begin
                bad++; $display("FAIL lsb_lane bit=%0d got=%b exp=%b", i, out_lane, {3'b000, lane0_exp[7-i]});
            end
            total++;
            if (out_idle !== 1'b0) begin
                bad++; $display("FAIL lsb_idle bit=%0d got=%b exp=0", i, out_idle);
            end
        end
        dir = 1'b0;
    endtask

    // Three words with IN_VALID held: ready only on the initial and load edges.
    task automatic test_back_to_back();
        logic [31:0] words [3];
        words[0] = 32'h1122_3344;
        words[1] = 32'hF0E1_D2C3;
        words[2] = 32'h8001_7FFE;
        for (int j = 0; j < 32; j++) begin
            in_valid = (j <= 16);
            in_data  = (j <= 16) ? words[j/8] : 32'h0;
            #1;
            if (j <= 16) begin
                total++;
                if (in_ready !== (j % 8 == 0)) begin
                    bad++; $display("FAIL b2b_ready cyc=%0d got=%b exp=%b", j, in_ready, (j % 8 == 0));
                end
            end
            tick();
            if (j >= 8) begin
                total++;
                if (out_lane !== lanes_bit(words[(j-8)/8], (j-8)%8)) begin
                    bad++; $display("FAIL b2b_lane cyc=%0d got=%b exp=%b", j, out_lane, lanes_bit(words[(j-8)/8], (j-8)%8));
                end
                total++;
                if (out_idle !== 1'b0 || out_frame !== ((j-8)%8 == 0)) begin
                    bad++; $display("FAIL b2b_flags cyc=%0d got=%b/%b", j, out_idle, out_frame);
                end
            end
        end
        in_valid = 1'b0;
    endtask

    // ENB low for 5 cycles after bit 3 of a data symbol.
    task automatic test_enb_stall();
        logic [31:0] w;
        logic [3:0]  frozen;
        w = 32'h5AC3_96E1;
        in_valid = 1'b1;
        in_data  = w;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (out_lane !== lanes_bit(w, i)) begin
                bad++; $display("FAIL stall_pre bit=%0d got=%b exp=%b", i, out_lane, lanes_bit(w, i));
            end
        end
        frozen   = lanes_bit(w, 3);
        enb      = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if (in_ready !== 1'b0) begin
                bad++; $display("FAIL stall_ready cyc=%0d got=%b exp=0", i, in_ready);
            end
            tick();
            total++;
            if (out_lane !== frozen || out_frame !== 1'b0 || out_idle !== 1'b0) begin
                bad++; $display("FAIL stall_hold cyc=%0d got=%b/%b/%b exp=%b/0/0", i, out_lane, out_frame, out_idle, frozen);
            end
        end
        enb      = 1'b1;
        in_valid = 1'b0;
        for (int i = 4; i < 8; i++) begin
            tick();
            total++;
            if (out_lane !== lanes_bit(w, i) || out_frame !== 1'b0) begin
                bad++; $display("FAIL stall_post bit=%0d got=%b exp=%b", i, out_lane, lanes_bit(w, i));
            end
        end
        tick();
        total++;
        if (out_frame !== 1'b1 || out_idle !== 1'b1 || out_lane !== 4'b1111) begin
            bad++; $display("FAIL stall_next got=%b/%b/%b exp=1/1/1111", out_frame, out_idle, out_lane);
        end
        repeat (7) tick();
    endtask

    // RESET at bit 5 of an idle symbol while a word sits in the buffer.
    task automatic test_reset_mid();
        tick();
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL rmid_ready got=%b exp=1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL rmid_full got=%b exp=0", in_ready);
        end
        repeat (4) tick();
        reset = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL rmid_rst_ready got=%b exp=0", in_ready);
        end
        tick();
        total++;
        if (out_lane !== 4'b0000 || out_idle !== 1'b1 || out_frame !== 1'b0) begin
            bad++; $display("FAIL rmid_rst got=%b/%b/%b exp=0000/1/0", out_lane, out_idle, out_frame);
        end
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            total++;
            if (out_lane !== {4{idle_v[7-(i%8)]}} || out_idle !== 1'b1 || out_frame !== (i % 8 == 0)) begin
                bad++; $display("FAIL rmid_after cyc=%0d got=%b/%b/%b exp=%b/1/%b", i, out_lane, out_idle, out_frame, {4{idle_v[7-(i%8)]}}, (i % 8 == 0));
            end
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        idle_v = 8'hBC;
        test_reset();
        test_idle();
        test_word_msb();
        test_word_lsb();
        test_back_to_back();
        test_enb_stall();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
